mp64_icache: RTL and testbench

MP64_ICACHE -- requirements
Module: mp64_icache

---
 rtl/mp64_icache_pkg.sv | 23 ++
 rtl/mp64_icache_array.sv | 38 +++
 rtl/mp64_icache.sv | 154 +++++++++++++++
 tb/tb_mp64_icache.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mp64_icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mp64_icache_pkg
//  Purpose  : Shared mp64 bus-size encodings and the I-cache refill FSM type.
//  Revision : 1.0 - initial release
// ============================================================================
package mp64_icache_pkg;

  // Bus transfer size encodings shared by every mp64 bus master.
  localparam logic [1:0] BUS_BYTE  = 2'd0;
  localparam logic [1:0] BUS_HALF  = 2'd1;
  localparam logic [1:0] BUS_WORD  = 2'd2;
  localparam logic [1:0] BUS_DWORD = 2'd3;

  // Refill sequencer: idle, fetching low doubleword, fetching high doubleword.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL0 = 2'd1,
    ST_FILL1 = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mp64_icache_array.sv
`default_nettype none
// ============================================================================
//  Module   : mp64_icache_array
//  Purpose  : Tag + data storage for the I-cache; asynchronous read so that the
//             hit decision can be made in the same cycle the address arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module mp64_icache_array #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 52,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [LINE_W-1:0]  wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic [TAG_W-1:0]   rtag,
  output logic [LINE_W-1:0]  rdata
);

  logic [TAG_W-1:0]  tag_mem  [1 << INDEX_W];
  logic [LINE_W-1:0] data_mem [1 << INDEX_W];

  // Whole-line write at the end of a refill; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[waddr]  <= wtag;
      data_mem[waddr] <= wdata;
    end
  end

  assign rtag  = tag_mem[raddr];
  assign rdata = data_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mp64_icache.sv
`default_nettype none
// ============================================================================
//  Module   : mp64_icache
//  Purpose  : 4 KiB direct-mapped instruction cache, 256 x 16-byte lines,
//             two-beat doubleword refill over the mp64 bus, with invalidation
//             and hit/miss statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module mp64_icache
  import mp64_icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] fetch_addr,
  input  logic        fetch_valid,
  output logic [63:0] fetch_data,
  output logic        fetch_hit,
  output logic        fetch_stall,
  output logic        bus_valid,
  output logic [63:0] bus_addr,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [1:0]  bus_size,
  input  logic        inv_all,
  input  logic        inv_line,
  input  logic [63:0] inv_addr,
  output logic [63:0] stat_hits,
  output logic [63:0] stat_misses
);

  localparam int LINE_BYTES  = 16;
  localparam int OFFSET_W    = $clog2(LINE_BYTES);
  localparam int INDEX_W     = 8;
  localparam int LINES       = 1 << INDEX_W;
  localparam int LINE_ADDR_W = 64 - OFFSET_W;
  localparam int TAG_W       = LINE_ADDR_W - INDEX_W;
  localparam int LINE_W      = 8 * LINE_BYTES;

  state_t                   state_q, state_d;
  logic [LINE_ADDR_W-1:0]   line_q, line_d;
  logic [63:0]              fill_lo_q, fill_lo_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [63:0]              hits_q, hits_d;
  logic [63:0]              misses_q, misses_d;
  logic                     array_we;

  logic [INDEX_W-1:0]       fetch_index;
  logic [TAG_W-1:0]         fetch_tag;
  logic [TAG_W-1:0]         rd_tag;
  logic [LINE_W-1:0]        rd_line;
  logic                     hit;
  logic                     unused_bits;

  assign fetch_index = fetch_addr[OFFSET_W +: INDEX_W];
  assign fetch_tag   = fetch_addr[63 -: TAG_W];
  assign unused_bits = ^{fetch_addr[2:0], inv_addr[63:OFFSET_W+INDEX_W], inv_addr[OFFSET_W-1:0]};

  mp64_icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_array (
    .clk   (clk),
    .we    (array_we),
    .waddr (line_q[INDEX_W-1:0]),
    .wtag  (line_q[LINE_ADDR_W-1:INDEX_W]),
    .wdata ({bus_rdata, fill_lo_q}),
    .raddr (fetch_index),
    .rtag  (rd_tag),
    .rdata (rd_line)
  );

  // Hit is only reported while no refill is in flight.
  assign hit = fetch_valid & valid_q[fetch_index] & (rd_tag == fetch_tag) & (state_q == ST_IDLE);

  assign fetch_hit   = hit;
  assign fetch_stall = fetch_valid & ~hit;
  assign fetch_data  = fetch_addr[3] ? rd_line[127:64] : rd_line[63:0];
  assign bus_valid   = (state_q != ST_IDLE);
  assign bus_addr    = {line_q, (state_q == ST_FILL1) ? 4'h8 : 4'h0};
  assign bus_wen     = 1'b0;
  assign bus_size    = BUS_DWORD;
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;

  // Refill sequencing, valid-bit maintenance and statistics.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    fill_lo_d = fill_lo_q;
    valid_d   = valid_q;
    hits_d    = hits_q + 64'(hit);
    misses_d  = misses_q;
    array_we  = 1'b0;

    // Single-line invalidate first so a refill completing this cycle still installs.
    if (inv_line) begin
      valid_d[inv_addr[OFFSET_W +: INDEX_W]] = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (fetch_valid && !hit) begin
          state_d  = ST_FILL0;
          line_d   = fetch_addr[63:OFFSET_W];
          misses_d = misses_q + 64'd1;
        end
      end
      ST_FILL0: begin
        if (bus_ready) begin
          fill_lo_d = bus_rdata;
          state_d   = ST_FILL1;
        end
      end
      ST_FILL1: begin
        if (bus_ready) begin
          array_we                        = 1'b1;
          valid_d[line_q[INDEX_W-1:0]]    = 1'b1;
          state_d                         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush-all wins: clears every line and abandons any refill in flight.
    if (inv_all) begin
      valid_d  = '0;
      array_we = 1'b0;
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State registers; tag/data arrays and refill buffers are left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
    line_q    <= line_d;
    fill_lo_q <= fill_lo_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_mp64_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mp64_icache
//  Purpose  : Self-checking bench for mp64_icache against a line-presence model
//             and a synthetic backing memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mp64_icache;
  import mp64_icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fetch_addr;
  logic        fetch_valid;
  logic [63:0] fetch_data;
  logic        fetch_hit;
  logic        fetch_stall;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [63:0] bus_rdata;
  logic        bus_ready;
  logic        bus_wen;
  logic [1:0]  bus_size;
  logic        inv_all;
  logic        inv_line;
  logic [63:0] inv_addr;
  logic [63:0] stat_hits;
  logic [63:0] stat_misses;

  always #5 clk = ~clk;

  mp64_icache dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_hit   (fetch_hit),
    .fetch_stall (fetch_stall),
    .bus_valid   (bus_valid),
    .bus_addr    (bus_addr),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .bus_wen     (bus_wen),
    .bus_size    (bus_size),
    .inv_all     (inv_all),
    .inv_line    (inv_line),
    .inv_addr    (inv_addr),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: which lines are resident, and the expected counters.
  bit          m_valid [256];
  logic [51:0] m_tag   [256];
  longint unsigned m_hits   = 0;
  longint unsigned m_misses = 0;
  logic [59:0] exp_line = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backing memory: byte at address a is a[7:0] ^ a[19:12].
  function automatic logic [63:0] mem_dword(input logic [63:0] a);
    logic [63:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      b = {a[7:3], 3'(i)} ^ a[19:12];
      r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  // Bus slave with random 1..4 cycle latency; checks beat order and attributes.
  initial begin : bus_model
    int beat;
    int lat;
    beat      = 0;
    lat       = 0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_ready) begin
        bus_ready = 1'b0;
        beat++;
        lat = int'($urandom_range(0, 3));
      end else if (!bus_valid) begin
        beat = 0;
      end else if (lat == 0) begin
        check("bus_addr", bus_addr, {exp_line, (beat != 0) ? 4'h8 : 4'h0});
        check("bus_wen", 64'(bus_wen), 64'd0);
        check("bus_size", 64'(bus_size), 64'(BUS_DWORD));
        bus_rdata = mem_dword(bus_addr);
        bus_ready = 1'b1;
      end else begin
        lat--;
      end
    end
  end

  task automatic do_fetch(input logic [63:0] a, output logic [63:0] d);
    logic [7:0] idx;
    bit         pred;
    bit         got;
    idx  = a[11:4];
    pred = m_valid[idx] && (m_tag[idx] == a[63:12]);
    @(negedge clk);
    fetch_addr  = a;
    fetch_valid = 1'b1;
    #1;
    check("hit_now", 64'(fetch_hit), 64'(pred));
    check("stall", 64'(fetch_stall), 64'(!pred));
    if (!pred) begin
      m_misses++;
      exp_line = a[63:4];
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        #1;
        got = fetch_hit;
      end
      check("fill_done", 64'(got), 64'd1);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[63:12];
    end
    d = fetch_data;
    check("data", fetch_data, mem_dword(a));
    m_hits++;
    @(posedge clk);
  endtask

  task automatic do_inv_all();
    @(negedge clk);
    fetch_valid = 1'b0;
    inv_all     = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic do_inv_line(input logic [63:0] a);
    @(negedge clk);
    fetch_valid = 1'b0;
    inv_line    = 1'b1;
    inv_addr    = a;
    @(negedge clk);
    inv_line = 1'b0;
    m_valid[a[11:4]] = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [63:0] d;
    logic [51:0] tag_sel [3];
    logic [63:0] a;
    tag_sel[0] = 52'h0;
    tag_sel[1] = 52'h1;
    tag_sel[2] = 52'hF_FFFF_FFFF_FFFF;
    foreach (m_valid[i]) m_valid[i] = 1'b0;

    rst         = 1'b1;
    fetch_addr  = '0;
    fetch_valid = 1'b0;
    inv_all     = 1'b0;
    inv_line    = 1'b0;
    inv_addr    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hits", stat_hits, 64'd0);
    check("rst_misses", stat_misses, 64'd0);
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_hit", 64'(fetch_hit), 64'd0);

    // Cold fill, refetch, other half of the same line.
    do_fetch(64'h0, d);
    check("line0_lo", d, 64'h0706050403020100);
    do_fetch(64'h0, d);
    do_fetch(64'h8, d);
    check("line0_hi", d, 64'h0F0E0D0C0B0A0908);

    // Conflict eviction.
    do_fetch(64'h1000, d);
    do_fetch(64'h0, d);

    // Flush-all, then single-line invalidate.
    do_inv_all();
    do_fetch(64'h0, d);
    do_fetch(64'h20, d);
    do_fetch(64'h30, d);
    do_inv_line(64'h20);
    do_fetch(64'h30, d);
    do_fetch(64'h20, d);

    // Flush-all during a refill must install nothing.
    @(negedge clk);
    exp_line    = 60'h200;
    fetch_addr  = 64'h2000;
    fetch_valid = 1'b1;
    m_misses++;
    #1;
    check("abort_stall", 64'(fetch_stall), 64'd1);
    @(negedge clk);
    #1;
    check("abort_bv", 64'(bus_valid), 64'd1);
    inv_all = 1'b1;
    @(negedge clk);
    inv_all     = 1'b0;
    fetch_valid = 1'b0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    #1;
    check("abort_idle", 64'(bus_valid), 64'd0);
    do_fetch(64'h2000, d);

    // Randomized mix of fetches and invalidations.
    for (int n = 0; n < 80; n++) begin
      int r;
      r = int'($urandom_range(0, 11));
      a = {tag_sel[$urandom_range(0, 2)], 4'($urandom_range(0, 7)), 4'(8 * $urandom_range(0, 1))};
      if (r == 0) do_inv_all();
      else if (r == 1) do_inv_line(a);
      else do_fetch(a, d);
    end

    @(negedge clk);
    fetch_valid = 1'b0;
    @(negedge clk);
    #1;
    check("stat_hits", stat_hits, 64'(m_hits));
    check("stat_misses", stat_misses, 64'(m_misses));
    check("hits_nonzero", 64'(stat_hits != 64'd0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
